// File: rtl/btb_assoc.sv
// Set-associative branch target buffer for the IF stage: combinational lookup of the fetch PC,
// training from resolved EX branches with 2-bit direction counters and round-robin replacement.
module btb_assoc #(
    parameter int         IDX_W    = 4,
    parameter int         WAYS     = 2,
    parameter logic [1:0] CNT_INIT = 2'b10,
    parameter int         STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cur_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_pc,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_mispredict,
    input  logic              inv_all,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int SETS  = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;
    localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [31:0]       tgt_q   [SETS][WAYS];
    logic [31:0]       tgt_d   [SETS][WAYS];
    logic [1:0]        cnt_q   [SETS][WAYS];
    logic [1:0]        cnt_d   [SETS][WAYS];
    logic [RR_W-1:0]   rr_q    [SETS];
    logic [RR_W-1:0]   rr_d    [SETS];
    logic [STAT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              lk_hit, up_hit, inv_found;
    logic [RR_W-1:0]   lk_way, up_way, inv_way, victim;
    logic              unused_pc_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign lk_idx         = cur_pc[IDX_W+1:2];
    assign lk_tag         = cur_pc[31:IDX_W+2];
    assign up_idx         = upd_pc[IDX_W+1:2];
    assign up_tag         = upd_pc[31:IDX_W+2];
    assign unused_pc_bits = ^{cur_pc[1:0], upd_pc[1:0]};

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = RR_W'(w);
            end
        end
    end

    // Descending scan so the lowest-index invalid way is the one left selected.
    always_comb begin
        up_hit    = 1'b0;
        up_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_hit = 1'b1;
                up_way = RR_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = RR_W'(w);
            end
        end
        victim = inv_found ? inv_way : rr_q[up_idx];
    end

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        mis_cnt_d = mis_cnt_q;
        if (upd_valid && upd_mispredict && mis_cnt_q != {STAT_W{1'b1}})
            mis_cnt_d = mis_cnt_q + 1'b1;
        if (inv_all) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
                rr_d[s]    = '0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    cnt_d[up_idx][up_way] = sat_inc(cnt_q[up_idx][up_way]);
                    tgt_d[up_idx][up_way] = upd_target;
                end else begin
                    cnt_d[up_idx][up_way] = sat_dec(cnt_q[up_idx][up_way]);
                end
            end else if (upd_taken) begin
                valid_d[up_idx][victim] = 1'b1;
                tag_d[up_idx][victim]   = up_tag;
                tgt_d[up_idx][victim]   = upd_target;
                cnt_d[up_idx][victim]   = CNT_INIT;
                // The pointer only advances when it actually supplied the victim.
                if (!inv_found)
                    rr_d[up_idx] = (rr_q[up_idx] == RR_W'(WAYS - 1)) ? '0 : rr_q[up_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
                for (int w = 0; w < WAYS; w++) cnt_q[s][w] <= 2'b00;
            end
            mis_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= tag_d;
            tgt_q <= tgt_d;
        end
    end

    assign pred_hit       = rst & lk_hit;
    assign pred_taken     = pred_hit & cnt_q[lk_idx][lk_way][1];
    assign pred_pc        = pred_taken ? tgt_q[lk_idx][lk_way] : cur_pc + 32'd4;
    assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed vector table followed by randomized traffic against a reference model.
module tb_btb_assoc;

    localparam int IDX_W = 4;
    localparam int WAYS  = 2;
    localparam int SETS  = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cur_pc;
    logic        pred_hit, pred_taken, pred_hit2, pred_taken2;
    logic [31:0] pred_pc, pred_pc2;
    logic        upd_valid, upd_taken, upd_mispredict, inv_all;
    logic [31:0] upd_pc, upd_target;
    logic [15:0] mispredict_cnt;
    logic [1:0]  mispredict_cnt2;

    always #5 clk = ~clk;

    btb_assoc #(.IDX_W(IDX_W), .WAYS(WAYS), .CNT_INIT(2'b10), .STAT_W(16)) u_dut (
        .clk(clk), .rst(rst), .cur_pc(cur_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .inv_all(inv_all), .mispredict_cnt(mispredict_cnt)
    );

    btb_assoc #(.IDX_W(IDX_W), .WAYS(WAYS), .CNT_INIT(2'b10), .STAT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .cur_pc(cur_pc),
        .pred_hit(pred_hit2), .pred_taken(pred_taken2), .pred_pc(pred_pc2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .inv_all(inv_all), .mispredict_cnt(mispredict_cnt2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain table of entries per set.
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_cnt   [SETS][WAYS];
    int          m_rr    [SETS];
    int          m_mis, m_mis2;

    function automatic int m_find(input logic [31:0] pc);
        int unsigned idx = (pc >> 2) % SETS;
        int unsigned tag = pc >> (IDX_W + 2);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) return w;
        return -1;
    endfunction

    task automatic model_edge();
        int unsigned idx, tag;
        int w, v;
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                m_rr[s] = 0;
                for (int k = 0; k < WAYS; k++) begin
                    m_valid[s][k] = 0;
                    m_cnt[s][k]   = 0;
                end
            end
            m_mis  = 0;
            m_mis2 = 0;
            return;
        end
        if (upd_valid && upd_mispredict) begin
            if (m_mis < 65535) m_mis++;
            if (m_mis2 < 3) m_mis2++;
        end
        if (inv_all) begin
            for (int s = 0; s < SETS; s++) begin
                m_rr[s] = 0;
                for (int k = 0; k < WAYS; k++) m_valid[s][k] = 0;
            end
        end else if (upd_valid) begin
            idx = (upd_pc >> 2) % SETS;
            tag = upd_pc >> (IDX_W + 2);
            w = m_find(upd_pc);
            if (w >= 0) begin
                if (upd_taken) begin
                    if (m_cnt[idx][w] < 3) m_cnt[idx][w]++;
                    m_tgt[idx][w] = upd_target;
                end else if (m_cnt[idx][w] > 0) begin
                    m_cnt[idx][w]--;
                end
            end else if (upd_taken) begin
                v = -1;
                for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[idx][k]) v = k;
                if (v < 0) begin
                    v = m_rr[idx];
                    m_rr[idx] = (m_rr[idx] + 1) % WAYS;
                end
                m_valid[idx][v] = 1;
                m_tag[idx][v]   = tag;
                m_tgt[idx][v]   = upd_target;
                m_cnt[idx][v]   = 2;
            end
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        um;
        logic        inv;
        logic [31:0] cpc;
        logic        eh;
        logic        et;
        logic [31:0] epc;
        int          emis;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utg, input logic um,
                                input logic inv, input logic [31:0] cpc, input logic eh,
                                input logic et, input logic [31:0] epc, input int emis);
        vec_t v;
        v.rst_n = rst_n; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.um = um;
        v.inv = inv; v.cpc = cpc; v.eh = eh; v.et = et; v.epc = epc; v.emis = emis;
        return v;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = (32'($urandom_range(1, 6)) << (IDX_W + 2)) | (32'($urandom_range(0, 3)) << 2)
            | 32'($urandom_range(0, 3));
        return p;
    endfunction

    vec_t tbl [19];

    initial begin
        int w;
        logic        e_hit, e_taken;
        logic [31:0] e_pc;

        // Each row: inputs held for one cycle, expected lookup before that cycle's edge.
        tbl[0]  = mk(0, 0, 0,       0, 0,       0, 0, 32'h040, 0, 0, 32'h044, 0);
        tbl[1]  = mk(0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h040, 0, 0, 32'h044, 0);
        tbl[2]  = mk(1, 0, 0,       0, 0,       0, 0, 32'h100, 0, 0, 32'h104, 0);
        tbl[3]  = mk(1, 1, 32'h100, 1, 32'h200, 1, 0, 32'h100, 0, 0, 32'h104, 0);
        tbl[4]  = mk(1, 1, 32'h100, 0, 32'h0,   0, 0, 32'h100, 1, 1, 32'h200, 1);
        tbl[5]  = mk(1, 1, 32'h100, 1, 32'h200, 1, 0, 32'h100, 1, 0, 32'h104, 1);
        tbl[6]  = mk(1, 1, 32'h100, 1, 32'h200, 0, 0, 32'h100, 1, 1, 32'h200, 2);
        tbl[7]  = mk(1, 1, 32'h100, 0, 32'h0,   1, 0, 32'h100, 1, 1, 32'h200, 2);
        tbl[8]  = mk(1, 0, 0,       0, 0,       0, 0, 32'h100, 1, 1, 32'h200, 3);
        tbl[9]  = mk(1, 1, 32'h500, 1, 32'h600, 1, 0, 32'h100, 1, 1, 32'h200, 3);
        tbl[10] = mk(1, 1, 32'h900, 1, 32'hA00, 1, 0, 32'h500, 1, 1, 32'h600, 4);
        tbl[11] = mk(1, 0, 0,       0, 0,       0, 0, 32'h100, 0, 0, 32'h104, 5);
        tbl[12] = mk(1, 1, 32'hD00, 1, 32'hE00, 0, 0, 32'h900, 1, 1, 32'hA00, 5);
        tbl[13] = mk(1, 0, 0,       0, 0,       0, 0, 32'h500, 0, 0, 32'h504, 5);
        tbl[14] = mk(1, 1, 32'h300, 0, 32'h700, 0, 0, 32'hD00, 1, 1, 32'hE00, 5);
        tbl[15] = mk(1, 0, 0,       0, 0,       0, 0, 32'h300, 0, 0, 32'h304, 5);
        tbl[16] = mk(1, 1, 32'h100, 1, 32'h200, 1, 1, 32'h900, 1, 1, 32'hA00, 5);
        tbl[17] = mk(1, 0, 0,       0, 0,       0, 0, 32'h900, 0, 0, 32'h904, 6);
        tbl[18] = mk(1, 0, 0,       0, 0,       0, 0, 32'h100, 0, 0, 32'h104, 6);

        rst = 1'b0; cur_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0; inv_all = 1'b0;
        @(posedge clk);
        model_edge();
        #1;

        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst_n; upd_valid = tbl[i].uv; upd_pc = tbl[i].upc;
            upd_taken = tbl[i].ut; upd_target = tbl[i].utg; upd_mispredict = tbl[i].um;
            inv_all = tbl[i].inv; cur_pc = tbl[i].cpc;
            @(negedge clk);
            check($sformatf("row%0d_hit", i),   32'(pred_hit),   32'(tbl[i].eh));
            check($sformatf("row%0d_taken", i), 32'(pred_taken), 32'(tbl[i].et));
            check($sformatf("row%0d_pc", i),    pred_pc,         tbl[i].epc);
            check($sformatf("row%0d_mis", i),   32'(mispredict_cnt), 32'(tbl[i].emis));
            check($sformatf("row%0d_mis2", i),  32'(mispredict_cnt2),
                  32'((tbl[i].emis > 3) ? 3 : tbl[i].emis));
            @(posedge clk);
            model_edge();
            #1;
        end

        for (int n = 0; n < 800; n++) begin
            rst            = ($urandom_range(0, 99) != 0);
            upd_valid      = ($urandom_range(0, 9) < 6);
            upd_pc         = rand_pc();
            upd_taken      = ($urandom_range(0, 9) < 6);
            upd_target     = $urandom;
            upd_mispredict = ($urandom_range(0, 9) < 3);
            inv_all        = ($urandom_range(0, 49) == 0);
            cur_pc         = ($urandom_range(0, 29) == 0) ? 32'hFFFF_FFFC : rand_pc();
            @(negedge clk);
            w       = m_find(cur_pc);
            e_hit   = rst && (w >= 0);
            e_taken = e_hit && (m_cnt[(cur_pc >> 2) % SETS][w] >= 2);
            e_pc    = e_taken ? m_tgt[(cur_pc >> 2) % SETS][w] : cur_pc + 32'd4;
            check("rand_hit",   32'(pred_hit),   32'(e_hit));
            check("rand_taken", 32'(pred_taken), 32'(e_taken));
            check("rand_pc",    pred_pc,         e_pc);
            check("rand_mis",   32'(mispredict_cnt),  32'(m_mis));
            check("rand_mis2",  32'(mispredict_cnt2), 32'(m_mis2));
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
